// File: rtl/sgpr_retire_pkg.sv
// Shared widths, legal retire masks and the queued entry record for the SGPR retire queue.
// The optional single-cycle bypass path is enabled with SGPR_RETIRE_BYPASS_EN.
package sgpr_retire_pkg;

   localparam int SGPR_ADDR_W   = 9;
   localparam int SGPR_WFID_W   = 6;
   localparam int SGPR_RQ_DEPTH = 4;

   localparam logic [3:0] MASK_1W = 4'b0001;
   localparam logic [3:0] MASK_2W = 4'b0011;
   localparam logic [3:0] MASK_4W = 4'b1111;

   typedef enum logic {
      SRC_SALU = 1'b0,
      SRC_LSU  = 1'b1
   } rr_src_e;

   typedef struct packed {
      logic [SGPR_ADDR_W-1:0] addr;
      logic [3:0]             mask;
      logic [SGPR_WFID_W-1:0] wfid;
   } retire_entry_t;

   function automatic logic mask_is_legal(input logic [3:0] m);
      return (m == MASK_1W) || (m == MASK_2W) || (m == MASK_4W);
   endfunction

endpackage

// File: rtl/sgpr_retire_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; full and empty decode only registered pointers.
// Used once per retire source inside sgpr_retire_queue (SGPR_RETIRE_BYPASS_EN has no effect here).
module sgpr_retire_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Same slot with differing wrap bits means the writer is a full lap ahead.
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/sgpr_retire_queue.sv
// Serialises SALU and LSU SGPR retire events onto the retired-operand bus, one per cycle, round-robin.
// Define SGPR_RETIRE_BYPASS_EN to let a lone event into an idle queue reach the outputs one cycle early.
module sgpr_retire_queue
   import sgpr_retire_pkg::*;
#(
   parameter int ADDR_W = SGPR_ADDR_W,
   parameter int WFID_W = SGPR_WFID_W,
   parameter int DEPTH  = SGPR_RQ_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              salu_retire_en,
   input  logic [ADDR_W-1:0] salu_retire_addr,
   input  logic [3:0]        salu_retire_mask,
   input  logic [WFID_W-1:0] salu_retire_wfid,
   output logic              salu_ready,
   input  logic              lsu_retire_en,
   input  logic [ADDR_W-1:0] lsu_retire_addr,
   input  logic [3:0]        lsu_retire_mask,
   input  logic [WFID_W-1:0] lsu_retire_wfid,
   output logic              lsu_ready,
   output logic              retired_operand_valid,
   output logic [ADDR_W-1:0] retired_operand_addr,
   output logic [3:0]        retired_operand_mask,
   output logic [WFID_W-1:0] retired_wfid,
   output logic              overflow_err
);

   // Handshake: an event transfers on a rising edge when x_retire_en and x_ready are both high.
   // x_ready depends only on registered FIFO state, never on x_retire_en; the output bus has no back-pressure.

   retire_entry_t salu_entry, lsu_entry, salu_head, lsu_head;
   logic          salu_full, salu_empty, lsu_full, lsu_empty;
   logic          salu_evt, lsu_evt, salu_legal, lsu_legal;
   logic          salu_accept, lsu_accept, salu_drop, lsu_drop;
   logic          salu_bypass, lsu_bypass, salu_push, lsu_push;
   logic          grant_salu, grant_lsu;

   rr_src_e       rr_q, rr_d;
   logic          valid_q, valid_d;
   retire_entry_t out_q, out_d;
   logic          err_q, err_d;

   assign salu_entry = {salu_retire_addr, salu_retire_mask, salu_retire_wfid};
   assign lsu_entry  = {lsu_retire_addr, lsu_retire_mask, lsu_retire_wfid};

   // An all-zero mask retires nothing, so it is silently ignored rather than flagged.
   assign salu_evt    = salu_retire_en && (salu_retire_mask != 4'b0000);
   assign lsu_evt     = lsu_retire_en && (lsu_retire_mask != 4'b0000);
   assign salu_legal  = mask_is_legal(salu_retire_mask);
   assign lsu_legal   = mask_is_legal(lsu_retire_mask);
   assign salu_accept = salu_evt && salu_legal && !salu_full;
   assign lsu_accept  = lsu_evt && lsu_legal && !lsu_full;
   assign salu_drop   = salu_evt && (!salu_legal || salu_full);
   assign lsu_drop    = lsu_evt && (!lsu_legal || lsu_full);

`ifdef SGPR_RETIRE_BYPASS_EN
   assign salu_bypass = salu_accept && salu_empty && lsu_empty && !lsu_retire_en;
   assign lsu_bypass  = lsu_accept && salu_empty && lsu_empty && !salu_retire_en;
`else
   assign salu_bypass = 1'b0;
   assign lsu_bypass  = 1'b0;
`endif

   assign salu_push = salu_accept && !salu_bypass;
   assign lsu_push  = lsu_accept && !lsu_bypass;

   assign grant_salu = !salu_empty && (lsu_empty || (rr_q == SRC_SALU));
   assign grant_lsu  = !lsu_empty && (salu_empty || (rr_q == SRC_LSU));

   sgpr_retire_fifo #(.WIDTH($bits(retire_entry_t)), .DEPTH(DEPTH)) u_salu_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (salu_push),
      .data_i  (salu_entry),
      .pop_i   (grant_salu),
      .full_o  (salu_full),
      .empty_o (salu_empty),
      .head_o  (salu_head)
   );

   sgpr_retire_fifo #(.WIDTH($bits(retire_entry_t)), .DEPTH(DEPTH)) u_lsu_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (lsu_push),
      .data_i  (lsu_entry),
      .pop_i   (grant_lsu),
      .full_o  (lsu_full),
      .empty_o (lsu_empty),
      .head_o  (lsu_head)
   );

   always_comb begin
      rr_d    = rr_q;
      valid_d = grant_salu || grant_lsu || salu_bypass || lsu_bypass;
      out_d   = out_q;
      err_d   = err_q || salu_drop || lsu_drop;
      // The pointer only moves when both sources actually competed.
      if (!salu_empty && !lsu_empty) rr_d = grant_salu ? SRC_LSU : SRC_SALU;
      if (grant_salu)       out_d = salu_head;
      else if (grant_lsu)   out_d = lsu_head;
      else if (salu_bypass) out_d = salu_entry;
      else if (lsu_bypass)  out_d = lsu_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q    <= SRC_SALU;
         valid_q <= 1'b0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign salu_ready            = !salu_full;
   assign lsu_ready             = !lsu_full;
   assign retired_operand_valid = valid_q;
   assign retired_operand_addr  = out_q.addr;
   assign retired_operand_mask  = out_q.mask;
   assign retired_wfid          = out_q.wfid;
   assign overflow_err          = err_q;

endmodule

// File: tb/tb_sgpr_retire_queue.sv
// Scoreboarded random/directed bench for sgpr_retire_queue against a queue-level reference model.
// Honour SGPR_RETIRE_BYPASS_EN the same way as the RTL build.
module tb_sgpr_retire_queue;

   localparam int ADDR_W = 9;
   localparam int WFID_W = 6;
   localparam int DEPTH  = 4;
   localparam int W      = ADDR_W + 4 + WFID_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              salu_retire_en = 1'b0;
   logic [ADDR_W-1:0] salu_retire_addr = '0;
   logic [3:0]        salu_retire_mask = '0;
   logic [WFID_W-1:0] salu_retire_wfid = '0;
   logic              salu_ready;
   logic              lsu_retire_en = 1'b0;
   logic [ADDR_W-1:0] lsu_retire_addr = '0;
   logic [3:0]        lsu_retire_mask = '0;
   logic [WFID_W-1:0] lsu_retire_wfid = '0;
   logic              lsu_ready;
   logic              retired_operand_valid;
   logic [ADDR_W-1:0] retired_operand_addr;
   logic [3:0]        retired_operand_mask;
   logic [WFID_W-1:0] retired_wfid;
   logic              overflow_err;

   sgpr_retire_queue #(.ADDR_W(ADDR_W), .WFID_W(WFID_W), .DEPTH(DEPTH)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .salu_retire_en        (salu_retire_en),
      .salu_retire_addr      (salu_retire_addr),
      .salu_retire_mask      (salu_retire_mask),
      .salu_retire_wfid      (salu_retire_wfid),
      .salu_ready            (salu_ready),
      .lsu_retire_en         (lsu_retire_en),
      .lsu_retire_addr       (lsu_retire_addr),
      .lsu_retire_mask       (lsu_retire_mask),
      .lsu_retire_wfid       (lsu_retire_wfid),
      .lsu_ready             (lsu_ready),
      .retired_operand_valid (retired_operand_valid),
      .retired_operand_addr  (retired_operand_addr),
      .retired_operand_mask  (retired_operand_mask),
      .retired_wfid          (retired_wfid),
      .overflow_err          (overflow_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_sq[$];
   logic [W-1:0] m_lq[$];
   bit           m_rr  = 1'b0;
   bit           m_err = 1'b0;

   function automatic bit legal(input logic [3:0] m);
      return (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model for one rising edge: the queue heads seen before the edge compete,
   // the winner goes to the expected output stream, then the new events are accepted or dropped.
   task automatic model_edge(input bit se, input logic [W-1:0] s_ent, input bit le, input logic [W-1:0] l_ent);
      bit s_rdy, l_rdy, idle, s_byp, l_byp;
      logic [3:0] sm, lm;
      s_rdy = (m_sq.size() < DEPTH);
      l_rdy = (m_lq.size() < DEPTH);
      idle  = (m_sq.size() == 0) && (m_lq.size() == 0);
      if (m_sq.size() > 0 && m_lq.size() > 0) begin
         if (!m_rr) exp_q.push_back(m_sq.pop_front());
         else       exp_q.push_back(m_lq.pop_front());
         m_rr = !m_rr;
      end else if (m_sq.size() > 0) exp_q.push_back(m_sq.pop_front());
      else if (m_lq.size() > 0)     exp_q.push_back(m_lq.pop_front());
      s_byp = 1'b0;
      l_byp = 1'b0;
`ifdef SGPR_RETIRE_BYPASS_EN
      s_byp = idle && !le;
      l_byp = idle && !se;
`endif
      sm = s_ent[WFID_W+:4];
      lm = l_ent[WFID_W+:4];
      if (se && sm != 4'b0000) begin
         if (!legal(sm) || !s_rdy) m_err = 1'b1;
         else if (s_byp)           exp_q.push_back(s_ent);
         else                      m_sq.push_back(s_ent);
      end
      if (le && lm != 4'b0000) begin
         if (!legal(lm) || !l_rdy) m_err = 1'b1;
         else if (l_byp)           exp_q.push_back(l_ent);
         else                      m_lq.push_back(l_ent);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit se, input logic [ADDR_W-1:0] sa, input logic [3:0] sm, input logic [WFID_W-1:0] sw,
                       input bit le, input logic [ADDR_W-1:0] la, input logic [3:0] lm, input logic [WFID_W-1:0] lw);
      @(negedge clk);
      salu_retire_en   = se;
      salu_retire_addr = sa;
      salu_retire_mask = sm;
      salu_retire_wfid = sw;
      lsu_retire_en    = le;
      lsu_retire_addr  = la;
      lsu_retire_mask  = lm;
      lsu_retire_wfid  = lw;
      check("salu_ready", salu_ready, m_sq.size() < DEPTH);
      check("lsu_ready", lsu_ready, m_lq.size() < DEPTH);
      check("overflow_err", overflow_err, m_err);
      model_edge(se, {sa, sm, sw}, le, {la, lm, lw});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0);
   endtask

   task automatic check_reset_vals();
      check("rst_valid", retired_operand_valid, 0);
      check("rst_addr", retired_operand_addr, 0);
      check("rst_mask", retired_operand_mask, 0);
      check("rst_wfid", retired_wfid, 0);
      check("rst_salu_ready", salu_ready, 1);
      check("rst_lsu_ready", lsu_ready, 1);
      check("rst_overflow_err", overflow_err, 0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic async_reset();
      salu_retire_en = 1'b0;
      lsu_retire_en  = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      m_sq.delete();
      m_lq.delete();
      exp_q.delete();
      m_rr  = 1'b0;
      m_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] got;
      if (rst_n && retired_operand_valid) begin
         got = {retired_operand_addr, retired_operand_mask, retired_wfid};
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got %0h expected no output at %0t", got, $time);
         end else begin
            check("retired_entry", got, exp_q.pop_front());
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- stimulus ----------------
   logic [3:0] mask_tbl [8];

   initial begin
      mask_tbl[0] = 4'b0001; mask_tbl[1] = 4'b0011; mask_tbl[2] = 4'b1111; mask_tbl[3] = 4'b0001;
      mask_tbl[4] = 4'b0011; mask_tbl[5] = 4'b1111; mask_tbl[6] = 4'b0000; mask_tbl[7] = 4'b0101;

      #2 check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;

      // single SALU event: latency and a single pulse
      step(1, 9'h010, 4'b0011, 6'd5, 0, '0, '0, '0);
`ifdef SGPR_RETIRE_BYPASS_EN
      check("lat_edge_e", retired_operand_valid, 1);
      idle(1);
      check("lat_edge_e1", retired_operand_valid, 0);
`else
      check("lat_edge_e", retired_operand_valid, 0);
      idle(1);
      check("lat_edge_e1", retired_operand_valid, 1);
      check("lat_addr", retired_operand_addr, 9'h010);
      check("lat_mask", retired_operand_mask, 4'b0011);
      check("lat_wfid", retired_wfid, 6'd5);
`endif
      idle(3);

      // both sources stream for 8 cycles
      for (int i = 0; i < 8; i++)
         step(1, 9'h020 + 9'(i), 4'b0011, 6'd1, 1, 9'h040 + 9'(i), 4'b0001, 6'd2);
      idle(12);
      async_reset();

      // fill SALU while LSU streams, then push beyond capacity
      for (int i = 0; i < 10; i++)
         step(1, 9'h060 + 9'(i), 4'b1111, 6'd3, 1, 9'h080 + 9'(i), 4'b0001, 6'd4);
      idle(12);
      check("err_sticky", overflow_err, 1);
      async_reset();

      // illegal and empty LSU masks
      step(0, '0, '0, '0, 1, 9'h0a0, 4'b0101, 6'd7);
      idle(3);
      check("err_bad_mask", overflow_err, 1);
      async_reset();
      step(0, '0, '0, '0, 1, 9'h0a1, 4'b0000, 6'd7);
      idle(3);
      check("err_zero_mask", overflow_err, 0);

      // reset mid-burst with entries queued
      for (int i = 0; i < 3; i++)
         step(1, 9'h0c0 + 9'(i), 4'b0001, 6'd8, 1, 9'h0d0 + 9'(i), 4'b0011, 6'd9);
      async_reset();
      idle(6);

      // pointer wrap: 20 SALU events, two every three cycles
      for (int i = 0; i < 20; i++) begin
         step(1, 9'h100 + 9'(i), mask_tbl[i % 3], 6'(i), 0, '0, '0, '0);
         if (i % 2 == 1) idle(1);
      end
      idle(8);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 6, 9'($urandom), mask_tbl[$urandom_range(0, 7)], 6'($urandom),
              $urandom_range(0, 9) < 6, 9'($urandom), mask_tbl[$urandom_range(0, 7)], 6'($urandom));
         if (i == 200) async_reset();
      end
      idle(2 * DEPTH + 4);
      check("exp_q_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sgpr_retire_queue.md
Name: sgpr_retire_queue

Overview:
- Collects SGPR write-back (retire) events from the SALU and LSU and serialises them, one per cycle, onto the retired-operand bus.
- That bus drives the issue-stage SGPR dependency comparators, which clear the scoreboard busy bits.
- Sits between the functional-unit write-back ports and the issue scoreboard.
- Buffers each source in a small FIFO and arbitrates round-robin so simultaneous retires are never lost.

Parameters:
- ADDR_W, 9, SGPR address width; matches SGPR_ADDR_LENGTH.
- WFID_W, 6, wavefront id width.
- DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- salu_retire_en  in  1  SALU retire event strobe.
- salu_retire_addr  in  ADDR_W  base SGPR address.
- salu_retire_mask  in  4  contiguous word mask from bit0: 0001, 0011 or 1111.
- salu_retire_wfid  in  WFID_W  wavefront of the SALU event.
- salu_ready  out  1  SALU FIFO not full.
- lsu_retire_en  in  1  LSU retire event strobe.
- lsu_retire_addr  in  ADDR_W  base SGPR address.
- lsu_retire_mask  in  4  contiguous word mask.
- lsu_retire_wfid  in  WFID_W  wavefront of the LSU event.
- lsu_ready  out  1  LSU FIFO not full.
- retired_operand_valid  out  1  one-cycle pulse per serialised event.
- retired_operand_addr  out  ADDR_W  base address of the event.
- retired_operand_mask  out  4  mask of the event.
- retired_wfid  out  WFID_W  wavefront of the event.
- overflow_err  out  1  sticky: an event was dropped or carried an illegal mask.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both FIFOs empty.
  - Round-robin pointer set to SALU.
  - retired_operand_valid, addr, mask and wfid all 0.
  - overflow_err 0; salu_ready and lsu_ready 1.
  - An event in flight is discarded; all state returns to reset values.
- Enqueue:
  - On a rising edge with x_retire_en=1 and x_ready=1, push {addr, mask, wfid} into source x's FIFO.
  - x_ready is the registered not-full flag. A push is refused when the FIFO is full, even if a pop happens the same cycle.
  - x_retire_en=1 with x_ready=0: event dropped, overflow_err set.
  - mask 0000: ignored, nothing pushed, no error.
  - mask not in {0001, 0011, 1111}: dropped, overflow_err set.
- Arbitration (combinational on the FIFO heads):
  - Only one head non-empty: that source is granted.
  - Both heads non-empty: the source named by the rr pointer is granted, then the pointer flips to the other source.
  - The pointer is unchanged when only one source is requesting.
- Output:
  - The granted head is popped and registered into the retired_* outputs on the same edge, with retired_operand_valid=1.
  - With no grant, valid=0 and addr/mask/wfid hold their last values.
  - Downstream never stalls; every valid pulse is consumed.
- Latency: event sampled at edge E appears on the outputs after edge E+1 (2 cycles) when uncontended. Each extra cycle of contention adds 1 cycle.
- Throughput: 1 event per cycle aggregate. Each source drains within 2*DEPTH cycles under full contention.
- Pointers: FIFO read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full means low bits equal and MSB differs.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen; occupancy is unchanged.
- Ordering: per-source order is preserved. Cross-source order is arbitration order.
- overflow_err clears only on reset.

Optional Feature:
- Macro: SGPR_RETIRE_BYPASS_EN.
- Defined: when a source's FIFO is empty, the other FIFO is empty, and the other source is not retiring this cycle, the input event is written straight into the output registers at edge E (1-cycle latency). The FIFO is not written.
- Defined, both sources retire into empty FIFOs in the same cycle: no bypass; both events are enqueued and normal arbitration applies.
- Not defined: the 2-cycle path is always used.

Decomposition:
- Package sgpr_retire_pkg holds:
  - the width defaults;
  - the legal mask constants MASK_1W=0001, MASK_2W=0011, MASK_4W=1111;
  - an entry record {addr, mask, wfid}.
- Sub-module sgpr_retire_fifo: a parameterised synchronous FIFO with push, pop, full, empty and head outputs, instantiated once per source.
- The arbiter, mask check and output registers live in the top level.

Test Plan:
- Single SALU event, addr=0x010, mask=0011, wfid=5 → valid pulse 2 cycles later (1 with bypass) carrying 0x010/0011/5; a single pulse only.
- Both sources retire every cycle for 8 cycles (SALU addrs 0x20..0x27, LSU 0x40..0x47), DEPTH=4 → outputs alternate SALU/LSU starting with SALU. The ready signals deassert when the FIFOs fill, and only accepted events appear, in per-source order.
- Fill the SALU FIFO with 4 events while the LSU streams, then assert a 5th SALU event with salu_ready=0 → event absent from the output, overflow_err=1 and stays 1.
- LSU mask=0101 → not output, overflow_err=1. LSU mask=0000 → not output, overflow_err unchanged.
- Assert rst_n low mid-burst with 3 entries queued → outputs, ready and error return to reset values at once; no stale entries appear after release.
- Wrap test: 20 SALU events pushed 2 per 3 cycles → all 20 output in order, addresses intact across pointer wrap.
